// File: rtl/line_refill.sv
// Cache line refill engine: streams an 8-word line from main memory into the
// data array, then commits the tag/valid entry and pulses done.
//
// state | meaning
// IDLE  | waiting for start; line address latched on acceptance
// FILL  | issuing 8 reads and writing returned words into the data array
// TAG   | one-cycle tag/valid write after all data words are in place
// DONE  | one-cycle completion pulse, then back to IDLE
module line_refill #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] CPU_addr,
  input  logic        start,
  output logic        main_mem_en,
  output logic [12:0] main_mem_addr,
  input  logic [31:0] main_mem_dout,
  output logic [31:0] cache_data_din,
  output logic        cache_data_we,
  output logic [8:0]  cache_data_addr,
  output logic        tag_we,
  output logic [5:0]  tag_addr,
  output logic [21:0] tag_din,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FILL, TAG, DONE} state_t;

  state_t               state;
  logic [26:0]          line_q;
  logic [2:0]           issue_cnt;
  logic [2:0]           wr_cnt;
  logic [MEM_LAT-1:0]   vpipe;
  logic                 unused_offset_bits;

  assign unused_offset_bits = ^CPU_addr[4:0];

  // Address outputs are straight register concatenations, so they stay glitch-free.
  assign main_mem_addr   = {line_q[9:0], issue_cnt};
  assign cache_data_addr = {line_q[5:0], wr_cnt};
  assign cache_data_we   = vpipe[MEM_LAT-1];
  assign cache_data_din  = main_mem_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      line_q      <= '0;
      issue_cnt   <= '0;
      wr_cnt      <= '0;
      vpipe       <= '0;
      main_mem_en <= 1'b0;
      tag_we      <= 1'b0;
      tag_addr    <= '0;
      tag_din     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      vpipe[0] <= main_mem_en;
      for (int k = 1; k < MEM_LAT; k++) vpipe[k] <= vpipe[k-1];
      tag_we <= 1'b0;
      done   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            line_q      <= CPU_addr[31:5];
            issue_cnt   <= '0;
            wr_cnt      <= '0;
            vpipe       <= '0;
            main_mem_en <= 1'b1;
            busy        <= 1'b1;
            state       <= FILL;
          end
        end
        FILL: begin
          if (main_mem_en) begin
            if (issue_cnt == 3'd7) main_mem_en <= 1'b0;
            else                   issue_cnt   <= issue_cnt + 3'd1;
          end
          // Tag commits only after the last data word lands.
          if (cache_data_we) begin
            wr_cnt <= wr_cnt + 3'd1;
            if (wr_cnt == 3'd7) begin
              state    <= TAG;
              tag_we   <= 1'b1;
              tag_addr <= line_q[5:0];
              tag_din  <= {1'b1, line_q[26:6]};
            end
          end
        end
        TAG: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
